// File: rtl/ppu_pixel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pixel_shifter_pkg
// Purpose  : Shared PPU types, sizes and the BGP palette lookup.
// Revision : 1.0
// ============================================================================
package ppu_pixel_shifter_pkg;

    localparam int LCD_WIDTH     = 160;
    localparam int BG_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [7:0] lcdc;
        logic [7:0] scy;
        logic [7:0] scx;
        logic [7:0] bgp;
    } ppu_regs_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] color;
    } ppu_pixel_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISCARD = 2'd1,
        S_OUTPUT  = 2'd2,
        S_DONE    = 2'd3
    } shifter_state_t;

    function automatic logic [1:0] bgp_map(input logic [7:0] palette, input logic [1:0] color);
        logic [1:0] shade;
        case (color)
            2'd0:    shade = palette[1:0];
            2'd1:    shade = palette[3:2];
            2'd2:    shade = palette[5:4];
            default: shade = palette[7:6];
        endcase
        return shade;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pixel_fifo
// Purpose  : Synchronous circular pixel FIFO with flush; BG and sprite paths.
// Revision : 1.0
// ============================================================================
module ppu_pixel_fifo
    import ppu_pixel_shifter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  ppu_pixel_t push_px,
    input  logic       pop,
    input  logic       flush,
    output ppu_pixel_t pop_px,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ppu_pixel_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push_ok;
    logic            pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // Flush drops a coincident push, so it is not an overflow either.
    assign push_ok  = push & ~full & ~flush;
    assign pop_ok   = pop & ~empty & ~flush;
    assign overflow = push & full & ~flush;
    assign pop_px   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_px;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppu_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pixel_shifter
// Purpose  : BG pixel consumer: fine-scroll discard, BGP mapping, LCD output.
// Revision : 1.0
// ============================================================================
module ppu_pixel_shifter
    import ppu_pixel_shifter_pkg::*;
#(
    parameter int DEPTH  = BG_FIFO_DEPTH,
    parameter int LINE_W = LCD_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  ppu_regs_t  regs,
    input  logic [7:0] y_screen,
    input  logic       line_start,
    input  logic       flush,
    input  logic       stall,
    input  logic       bg_push_en,
    input  ppu_pixel_t bg_push_px,
    output logic       bg_fifo_full,
    output logic       bg_fifo_empty,
    output logic       lcd_px_valid,
    output logic [1:0] lcd_color,
    output logic [7:0] lcd_x,
    output logic [7:0] lcd_y,
    output logic       line_done,
    output logic       overflow_err
);

    shifter_state_t state, state_d;
    logic [2:0]     disc_cnt, disc_d;
    logic [7:0]     x_cnt, x_d;
    logic           pop;
    logic           out_pop;
    logic           done_d;
    logic           fifo_overflow;
    ppu_pixel_t     head_px;
    logic           unused_bits;

    assign unused_bits = ^{regs.lcdc[7:1], regs.scy, regs.scx[7:3], head_px.valid};

    // A restart or flush this cycle empties the FIFO, so nothing is popped.
    assign pop = dot_en & ~stall & ~bg_fifo_empty & ~flush & ~line_start
               & ((state == S_DISCARD) | (state == S_OUTPUT));

    ppu_pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_bg_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bg_push_en),
        .push_px  (bg_push_px),
        .pop      (pop),
        .flush    (flush | line_start),
        .pop_px   (head_px),
        .full     (bg_fifo_full),
        .empty    (bg_fifo_empty),
        .overflow (fifo_overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            disc_cnt <= '0;
            x_cnt    <= '0;
        end else begin
            state    <= state_d;
            disc_cnt <= disc_d;
            x_cnt    <= x_d;
        end
    end

    always_comb begin
        state_d = state;
        disc_d  = disc_cnt;
        x_d     = x_cnt;
        out_pop = 1'b0;
        done_d  = 1'b0;
        if (line_start) begin
            x_d = '0;
            if (regs.scx[2:0] == 3'd0) begin
                state_d = S_OUTPUT;
            end else begin
                state_d = S_DISCARD;
                disc_d  = regs.scx[2:0];
            end
        end else begin
            case (state)
                S_DISCARD: begin
                    if (pop) begin
                        disc_d = disc_cnt - 3'd1;
                        if (disc_cnt == 3'd1) begin
                            state_d = S_OUTPUT;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (pop) begin
                        out_pop = 1'b1;
                        x_d     = x_cnt + 8'd1;
                        if (x_cnt == 8'(LINE_W - 1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_px_valid <= 1'b0;
            lcd_color    <= 2'b00;
            lcd_x        <= '0;
            lcd_y        <= '0;
            line_done    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            lcd_px_valid <= out_pop;
            line_done    <= done_d;
            if (fifo_overflow) begin
                overflow_err <= 1'b1;
            end
            if (out_pop) begin
                lcd_color <= regs.lcdc[0] ? bgp_map(regs.bgp, head_px.color) : 2'b00;
                lcd_x     <= x_cnt;
                lcd_y     <= y_screen;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppu_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_pixel_shifter
// Purpose  : Scoreboard bench for ppu_pixel_shifter against a queue model.
// Revision : 1.0
// ============================================================================
module tb_ppu_pixel_shifter;
    import ppu_pixel_shifter_pkg::*;

    localparam int DEPTH  = 16;
    localparam int LINE_W = 160;

    typedef struct {
        int color;
        int x;
        int y;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dot_en = 1'b0;
    ppu_regs_t  regs = '0;
    logic [7:0] y_screen = '0;
    logic       line_start = 1'b0;
    logic       flush = 1'b0;
    logic       stall = 1'b0;
    logic       bg_push_en = 1'b0;
    ppu_pixel_t bg_push_px = '0;
    logic       bg_fifo_full, bg_fifo_empty, lcd_px_valid, line_done, overflow_err;
    logic [1:0] lcd_color;
    logic [7:0] lcd_x, lcd_y;

    ppu_pixel_shifter #(.DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset), .dot_en(dot_en), .regs(regs), .y_screen(y_screen),
        .line_start(line_start), .flush(flush), .stall(stall),
        .bg_push_en(bg_push_en), .bg_push_px(bg_push_px),
        .bg_fifo_full(bg_fifo_full), .bg_fifo_empty(bg_fifo_empty),
        .lcd_px_valid(lcd_px_valid), .lcd_color(lcd_color), .lcd_x(lcd_x), .lcd_y(lcd_y),
        .line_done(line_done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_on = 0;

    // Reference model: pixel queue plus line progress bookkeeping.
    int   mq[$];
    exp_t sb[$];
    bit   m_active, m_ovf, m_exp_valid, m_exp_done;
    int   m_skip, m_x;
    int   cur_scx = 0, cur_bgp = 8'hE4, cur_lcdc0 = 1, cur_y = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_active = 0; m_ovf = 0; m_exp_valid = 0; m_exp_done = 0;
        m_skip = 0; m_x = 0;
    endtask

    task automatic step(input bit ls, input bit fl, input bit de, input bit st,
                        input bit pe, input int pc);
        int   pre;
        int   c;
        exp_t e;
        @(negedge clk);
        #1;
        reset      = 1'b0;
        line_start = ls;
        flush      = fl;
        dot_en     = de;
        stall      = st;
        bg_push_en = pe;
        bg_push_px.color = 2'(pc);
        bg_push_px.valid = 1'($urandom_range(0, 1));
        regs.scx   = 8'(cur_scx);
        regs.bgp   = 8'(cur_bgp);
        regs.lcdc  = {7'($urandom), 1'(cur_lcdc0)};
        regs.scy   = 8'($urandom);
        y_screen   = 8'(cur_y);

        pre = mq.size();
        m_exp_valid = 0;
        m_exp_done  = 0;
        if (de && !st && !fl && !ls && m_active && pre > 0) begin
            c = mq.pop_front();
            if (m_skip > 0) begin
                m_skip--;
            end else begin
                e.color = cur_lcdc0 ? ((cur_bgp >> (2 * c)) & 3) : 0;
                e.x = m_x;
                e.y = cur_y;
                sb.push_back(e);
                m_exp_valid = 1;
                if (m_x == LINE_W - 1) begin
                    m_active = 0;
                    m_exp_done = 1;
                end
                m_x++;
            end
        end
        if (ls) begin
            m_active = 1;
            m_skip = cur_scx % 8;
            m_x = 0;
        end
        if (ls || fl) mq.delete();
        else if (pe) begin
            if (pre == DEPTH) m_ovf = 1;
            else mq.push_back(pc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        line_start = 0; flush = 0; dot_en = 0; stall = 0; bg_push_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_empty", bg_fifo_empty, 1);
        chk("rst_full", bg_fifo_full, 0);
        chk("rst_valid", lcd_px_valid, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_x", lcd_x, 0);
        chk("rst_y", lcd_y, 0);
        chk("rst_color", lcd_color, 0);
        chk("rst_done", line_done, 0);
        mon_on = 1;
    endtask

    // Monitor: compares every cycle; pops the scoreboard on each output pixel.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on && !reset) begin
                chk("px_valid", lcd_px_valid, m_exp_valid);
                chk("line_done", line_done, m_exp_done);
                chk("fifo_full", bg_fifo_full, mq.size() == DEPTH);
                chk("fifo_empty", bg_fifo_empty, mq.size() == 0);
                chk("overflow_err", overflow_err, m_ovf);
                if (lcd_px_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_px", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("lcd_color", lcd_color, e.color);
                        chk("lcd_x", lcd_x, e.x);
                        chk("lcd_y", lcd_y, e.y);
                    end
                end
            end
        end
    end

    task automatic run_pops(input int n);
        repeat (n) step(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        int pushed;
        int guard;
        do_reset();

        // Fine scroll of 3 with identity palette.
        cur_scx = 3; cur_bgp = 8'hE4; cur_lcdc0 = 1; cur_y = 7;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, i % 4);
        run_pops(12);

        // Inverted palette, then background disabled.
        cur_scx = 0; cur_bgp = 8'h1B; cur_y = 8;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, i);
        run_pops(6);
        cur_lcdc0 = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, i);
        run_pops(6);
        cur_lcdc0 = 1;

        // Fill under stall, overflow, then drain.
        cur_bgp = 8'hE4; cur_y = 9;
        step(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 1, 1, int'($urandom_range(0, 3)));
        run_pops(20);

        // Full line end with 8 pixels left over.
        do_reset();
        cur_scx = 0; cur_y = 20;
        step(1, 0, 1, 0, 0, 0);
        pushed = 0; guard = 0;
        while ((pushed < LINE_W + 8 || m_active) && guard < 2000) begin
            bit pe;
            pe = (pushed < LINE_W + 8) && (mq.size() < DEPTH);
            step(0, 0, 1, 0, pe, int'($urandom_range(0, 3)));
            if (pe) pushed++;
            guard++;
        end
        chk("line_end_timeout", guard < 2000, 1);
        run_pops(5);

        // Flush with push at x=40, then mid-line restart.
        cur_scx = 0; cur_y = 21;
        step(1, 0, 1, 0, 0, 0);
        guard = 0;
        while (m_x < 40 && guard < 500) begin
            step(0, 0, 1, 0, mq.size() < DEPTH, int'($urandom_range(0, 3)));
            guard++;
        end
        chk("flush_timeout", guard < 500, 1);
        step(0, 1, 1, 0, 1, 2);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1, int'($urandom_range(0, 3)));
        run_pops(4);
        step(1, 0, 1, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1, int'($urandom_range(0, 3)));
        run_pops(8);

        // Randomised traffic.
        do_reset();
        for (int n = 0; n < 5000; n++) begin
            bit ls;
            ls = (!m_active && $urandom_range(0, 19) == 0) || ($urandom_range(0, 999) == 0);
            if (ls) begin
                cur_scx   = int'($urandom_range(0, 255));
                cur_bgp   = int'($urandom_range(0, 255));
                cur_lcdc0 = int'($urandom_range(0, 7) != 0);
                cur_y     = (cur_y + 1) % 154;
            end
            step(ls, $urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 3)));
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
